// File: rtl/ros2_sub_msg_queue_pkg.sv
// Shared constants for the ROS2 subscriber message queue: slot geometry tied to the
// application payload size, write-FSM encodings and the length clamp helper.
package ros2_sub_msg_queue_pkg;
  localparam int ROS2_MAX_APP_DATA_LEN = 64;
  localparam int DEF_MAX_LEN           = ROS2_MAX_APP_DATA_LEN;
  localparam int DEF_SLOTS             = 4;
  localparam int DEF_CNT_W             = 16;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_FILL   = 2'd1,
    W_COMMIT = 2'd2
  } wstate_e;

  function automatic logic [7:0] cap_len(input logic [7:0] len, input int max_len);
    return (int'(len) > max_len) ? 8'(max_len) : len;
  endfunction
endpackage

// File: rtl/ros2_sub_slot_ram.sv
// Simple dual-port byte RAM holding all message slots; synchronous write, registered read.
module ros2_sub_slot_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_int,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk_int) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is reset; the array itself keeps no reset so it maps to block RAM.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ros2_sub_msg_queue.sv
// Subscriber-side message queue: one write slot being filled by the core plus a
// circular queue of committed slots read out by the host, with overflow accounting.
module ros2_sub_msg_queue
  import ros2_sub_msg_queue_pkg::*;
#(
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int SLOTS   = DEF_SLOTS,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int AW      = $clog2(MAX_LEN),
  localparam int PW      = $clog2(SLOTS),
  localparam int CW      = PW + 1
) (
  input  logic             clk_int,
  input  logic             rst_n,
  input  logic [AW-1:0]    sub_addr,
  input  logic             sub_ce,
  input  logic             sub_we,
  input  logic [7:0]       sub_wdata,
  input  logic [7:0]       sub_len,
  input  logic             sub_recv,
  output logic             msg_valid,
  output logic [7:0]       msg_len,
  input  logic [AW-1:0]    rd_addr,
  output logic [7:0]       rd_data,
  input  logic             msg_pop,
  output logic [CW-1:0]    msg_count,
  output logic             drop,
  output logic [CNT_W-1:0] overflow_cnt
);
  wstate_e          r_state, w_state_nxt;
  logic [PW-1:0]    r_head, r_tail, r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [7:0]       r_len [SLOTS];
  logic             r_drop;
  logic [CNT_W-1:0] r_ovf;

  logic w_byte_we, w_recv, w_pop, w_full, w_commit, w_discard;

  assign w_byte_we = sub_ce & sub_we;
  assign w_recv    = sub_recv & (r_state != W_COMMIT);
  assign w_pop     = msg_pop & (r_count != '0);
  assign w_full    = (r_count == CW'(SLOTS - 1));
  // A pop in the same cycle frees a slot first, so a full queue still accepts the commit.
  assign w_commit  = w_recv & (~w_full | w_pop);
  assign w_discard = w_recv & w_full & ~w_pop;

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) r_state <= W_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      W_IDLE: begin
        if (sub_recv)       w_state_nxt = W_COMMIT;
        else if (w_byte_we) w_state_nxt = W_FILL;
      end
      W_FILL:   if (sub_recv) w_state_nxt = W_COMMIT;
      W_COMMIT: w_state_nxt = W_IDLE;
      default:  w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
      r_ovf    <= '0;
      for (int i = 0; i < SLOTS; i++) r_len[i] <= '0;
    end else begin
      r_drop <= w_discard;
      if (w_discard && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
      if (w_commit) begin
        r_len[r_tail] <= cap_len(sub_len, MAX_LEN);
        r_tail        <= r_tail + 1'b1;
        r_wr_ptr      <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_commit, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  ros2_sub_slot_ram #(
    .DEPTH (SLOTS * MAX_LEN),
    .AW    (PW + AW)
  ) u_ram (
    .clk_int (clk_int),
    .rst_n   (rst_n),
    .i_we    (w_byte_we),
    .i_waddr ({r_wr_ptr, sub_addr}),
    .i_wdata (sub_wdata),
    .i_re    (r_count != '0),
    .i_raddr ({r_head, rd_addr}),
    .o_rdata (rd_data)
  );

  assign msg_valid    = (r_count != '0);
  assign msg_len      = r_len[r_head];
  assign msg_count    = r_count;
  assign drop         = r_drop;
  assign overflow_cnt = r_ovf;
endmodule
